pipeline_mem_ctrl: RTL and testbench
====================================

Name: pipeline_mem_ctrl

Overview:
- Services the stall side of the pipeline.
- The hazard unit decides which stages flush or hold on data/control dependencies. This block decides when the whole pipeline may advance, based on the instruction/data memory handshake (iREN/dREN/dWEN vs ihit/dhit).
- Sits between the MEM-stage control signals and the cache interface. Drives a global freeze that all pipeline latches AND with the hazard unit's per-stage enables.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles a data request may wait for dhit before err_timeout sets; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- dren_req  in  1  MEM-stage instruction is a load (LW/LL).
- dwen_req  in  1  MEM-stage instruction is a store (SW/SC).
- squash_MEM  in  1  MEM-stage instruction is being flushed; suppresses its data request.
- halt_MEM  in  1  MEM-stage instruction is HALT.
- ihit  in  1  instruction fetch complete.
- dhit  in  1  data access complete.
- dload  in  32  data returned by the cache (word_t).
- iREN  out  1  instruction read enable.
- dREN  out  1  data read enable.
- dWEN  out  1  data write enable.
- dload_out  out  32  load data presented to the MEM/WB latch.
- advance  out  1  all latches may capture this cycle.
- halted  out  1  processor halted (sticky).
- err_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  count of cycles with advance=0 (perf).
- dmem_ops  out  CNT_W  count of completed data accesses (perf).

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE; ihit_seen=0; dload_q=0; wd_cnt=0.
  - halted=0; err_timeout=0; counters=0.
  - Outputs during reset: iREN=1, dREN=dWEN=0, advance=0.
- req = (dren_req|dwen_req) & ~squash_MEM. If dren_req and dwen_req are both set, treat the access as a write.
- States:
  - IDLE: no pending data access, or a fresh request this cycle.
  - DWAIT: data request outstanding across more than one cycle.
  - DDONE: data completed, waiting for the fetch.
  - HALT: processor halted.
- Memory enables (combinational):
  - dREN = req & ~dwen_req & state∈{IDLE,DWAIT}.
  - dWEN = req & dwen_req & state∈{IDLE,DWAIT}.
  - iREN = (state != HALT).
- Completion terms:
  - data_ok = ~req | dhit | (state==DDONE).
  - inst_ok = ihit | ihit_seen.
  - advance = data_ok & inst_ok & (state != HALT).
- dload_out = dload when dhit, else dload_q when state==DDONE, else 0.
- Transitions:
  - IDLE/DWAIT, req & ~dhit → DWAIT.
  - IDLE/DWAIT, dhit & ~inst_ok → DDONE; capture dload into dload_q.
  - IDLE/DWAIT, advance → IDLE.
  - DDONE, inst_ok → IDLE. No re-issue of dREN/dWEN while in DDONE.
  - Any state, advance & halt_MEM → HALT; halted=1.
  - HALT is left only by RST.
- ihit_seen: set when ihit & ~advance; cleared on advance.
- Single-cycle hits: ihit and dhit in the same cycle give advance=1 with zero added latency.
- Watchdog:
  - wd_cnt increments each cycle in DWAIT with ~dhit; clears on leaving DWAIT.
  - wd_cnt == TIMEOUT_CYCLES-1 sets err_timeout (sticky). Pipeline behaviour is unchanged.
- squash_MEM rising in DWAIT: dREN/dWEN deassert the same cycle; next state = IDLE (or DDONE is not entered).

Optional Feature:
- MEMCTRL_PERF_EN defined:
  - stall_cycles increments when advance=0 & state!=HALT.
  - dmem_ops increments on each dhit.
  - Both counters wrap at 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- cpu_types_pkg: add memctrl_state_t enum {IDLE, DWAIT, DDONE, HALT}; reuse word_t.
- Sub-module memctrl_perf_cnt holds both counters; instantiated only under MEMCTRL_PERF_EN.

Test Plan:
- Load, ihit=1, dhit high 3 cycles after dREN, dload=0xDEADBEEF → advance=0 for 3 cycles, 1 on the hit cycle; dload_out=0xDEADBEEF.
- Store with dhit at cycle 2, ihit only at cycle 5 → DDONE at cycle 2; dWEN=0 in cycles 3-5; advance=1 at cycle 5; dload_q unused.
- Load with squash_MEM=1 → dREN never asserts; advance follows ihit alone.
- halt_MEM with ihit=1, no data access → halted=1 next cycle; iREN=0; advance=0 until RST.
- TIMEOUT_CYCLES=8, dhit withheld → err_timeout=1 after 8 DWAIT cycles; RST clears it and returns state to IDLE.
- With MEMCTRL_PERF_EN: 10 instructions containing 2 loads, each with 2 miss cycles → dmem_ops=2, stall_cycles=4.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word_t data word and the memory-controller state enum.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // IDLE : no data access pending, or a fresh request this cycle
    // DWAIT: data request outstanding for more than one cycle
    // DDONE: data side finished, still waiting on the instruction fetch
    // HALT : processor halted, left only through reset
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWAIT = 2'd1,
        DDONE = 2'd2,
        HALT  = 2'd3
    } memctrl_state_t;

endpackage

// File: rtl/memctrl_perf_cnt.sv
// Stall-cycle and data-access performance counters, both wrapping at 2^CNT_W.
// Latency: a count is visible on the outputs one cycle after its increment strobe.
// Backpressure: none; the counters only observe the pipeline.
//
// Ports: CLK/RST (sync, active-high); stall_inc/dmem_inc increment strobes;
//        stall_cycles/dmem_ops current counts.
module memctrl_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall_inc,
    input  logic             dmem_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] dmem_ops
);

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] dmem_ops_q, dmem_ops_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        dmem_ops_d     = dmem_ops_q;
        if (stall_inc) stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (dmem_inc)  dmem_ops_d     = dmem_ops_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            dmem_ops_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            dmem_ops_q     <= dmem_ops_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign dmem_ops     = dmem_ops_q;

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// Pipeline stall controller: turns the I/D memory handshake into a global advance/freeze.
// Latency: zero added cycles when ihit and dhit land together; a miss holds advance low until both sides finish.
// Backpressure: advance=0 freezes every pipeline latch; the memory enables are the only requests issued.
//
// Ports: CLK/RST (sync, active-high); dren_req/dwen_req/squash_MEM/halt_MEM from MEM stage;
//        ihit/dhit/dload from the caches; iREN/dREN/dWEN to the caches; dload_out to MEM/WB;
//        advance (global enable); halted, err_timeout (sticky); stall_cycles, dmem_ops (perf).
// Build option: define MEMCTRL_PERF_EN to include the performance counters; otherwise they read 0.
module pipeline_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dren_req,
    input  logic             dwen_req,
    input  logic             squash_MEM,
    input  logic             halt_MEM,
    input  logic             ihit,
    input  logic             dhit,
    input  word_t            dload,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output word_t            dload_out,
    output logic             advance,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] dmem_ops
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

    memctrl_state_t  state_q, state_d;
    logic            ihit_seen_q, ihit_seen_d;
    word_t           dload_q, dload_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            halted_q, halted_d;
    logic            err_timeout_q, err_timeout_d;

    logic req;
    logic can_issue;
    logic inst_ok;
    logic data_ok;

    // Both request bits set is treated as a store.
    assign req       = (dren_req | dwen_req) & ~squash_MEM;
    assign can_issue = (state_q == IDLE) || (state_q == DWAIT);
    assign inst_ok   = ihit | ihit_seen_q;
    assign data_ok   = ~req | dhit | (state_q == DDONE);

    // Reset overrides the registered state so the caches see a clean fetch request.
    assign advance = data_ok & inst_ok & (state_q != HALT) & ~RST;
    assign iREN    = RST | (state_q != HALT);
    assign dREN    = req & ~dwen_req & can_issue & ~RST;
    assign dWEN    = req & dwen_req & can_issue & ~RST;

    always_comb begin
        dload_out = '0;
        if (dhit)                  dload_out = dload;
        else if (state_q == DDONE) dload_out = dload_q;
    end

    always_comb begin
        state_d       = state_q;
        dload_d       = dload_q;
        halted_d      = halted_q;
        err_timeout_d = err_timeout_q;
        wd_cnt_d      = '0;

        case (state_q)
            IDLE, DWAIT: begin
                if (advance) begin
                    state_d = IDLE;
                end else if (req && dhit) begin
                    // Data finished before the fetch: hold the word until inst_ok.
                    state_d = DDONE;
                    dload_d = dload;
                end else if (req) begin
                    state_d = DWAIT;
                end else begin
                    // Request withdrawn (e.g. squashed while waiting).
                    state_d = IDLE;
                end
            end
            DDONE: begin
                if (inst_ok) state_d = IDLE;
            end
            default: state_d = HALT;
        endcase

        if (advance && halt_MEM) begin
            state_d  = HALT;
            halted_d = 1'b1;
        end

        // Watchdog only runs while a data request keeps waiting without a hit.
        if (state_q == DWAIT && state_d == DWAIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (TIMEOUT_CYCLES != 0 && wd_cnt_q == WD_LAST) err_timeout_d = 1'b1;
        end

        ihit_seen_d = advance ? 1'b0 : (ihit_seen_q | ihit);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            ihit_seen_q   <= 1'b0;
            dload_q       <= '0;
            wd_cnt_q      <= '0;
            halted_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ihit_seen_q   <= ihit_seen_d;
            dload_q       <= dload_d;
            wd_cnt_q      <= wd_cnt_d;
            halted_q      <= halted_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign halted      = halted_q;
    assign err_timeout = err_timeout_q;

`ifdef MEMCTRL_PERF_EN
    memctrl_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .CLK          (CLK),
        .RST          (RST),
        .stall_inc    (~advance & (state_q != HALT)),
        .dmem_inc     (dhit),
        .stall_cycles (stall_cycles),
        .dmem_ops     (dmem_ops)
    );
`else
    assign stall_cycles = '0;
    assign dmem_ops     = '0;
`endif

endmodule

// File: tb/tb_pipeline_mem_ctrl.sv
// Self-checking bench for pipeline_mem_ctrl: directed scenarios then randomized traffic vs a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_mem_ctrl;

    localparam int TO = 8;
`ifdef MEMCTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, dren_req, dwen_req, squash_MEM, halt_MEM, ihit, dhit;
    logic [31:0] dload, dload_out, stall_cycles, dmem_ops;
    logic        iREN, dREN, dWEN, advance, halted, err_timeout;

    always #5 CLK = ~CLK;

    pipeline_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .dren_req(dren_req), .dwen_req(dwen_req),
        .squash_MEM(squash_MEM), .halt_MEM(halt_MEM), .ihit(ihit), .dhit(dhit),
        .dload(dload), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .dload_out(dload_out),
        .advance(advance), .halted(halted), .err_timeout(err_timeout),
        .stall_cycles(stall_cycles), .dmem_ops(dmem_ops)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: per in-flight MEM instruction, has its data side / fetch side finished?
    bit          m_halt, m_data_done, m_inst_done, m_err;
    int          m_pend;          // consecutive cycles the current data request went unanswered
    logic [31:0] m_dval, m_stall, m_dops;

    // Samples of the last cycle's outputs for directed checks.
    logic        s_adv, s_dren, s_dwen, s_iren, s_halted, s_err;
    logic [31:0] s_dout, s_stall, s_dops;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_data_done = 0; m_inst_done = 0; m_err = 0;
        m_pend = 0; m_dval = '0; m_stall = '0; m_dops = '0;
    endtask

    task automatic cycle(input bit rst, input bit rd, input bit wr, input bit sq,
                         input bit hlt, input bit ih, input bit dh, input logic [31:0] dl);
        bit          req, e_iren, e_dren, e_dwen, e_adv;
        logic [31:0] e_dout;
        RST = rst; dren_req = rd; dwen_req = wr; squash_MEM = sq;
        halt_MEM = hlt; ihit = ih; dhit = dh; dload = dl;
        @(negedge CLK);
        s_adv = advance; s_dren = dREN; s_dwen = dWEN; s_iren = iREN; s_dout = dload_out;
        s_halted = halted; s_err = err_timeout; s_stall = stall_cycles; s_dops = dmem_ops;

        req = (rd | wr) & ~sq;
        if (rst) begin
            e_iren = 1; e_dren = 0; e_dwen = 0; e_adv = 0; e_dout = dload_out;
        end else if (m_halt) begin
            e_iren = 0; e_dren = 0; e_dwen = 0; e_adv = 0;
            e_dout = dh ? dl : 32'h0;
        end else begin
            e_iren = 1;
            e_dren = req & ~m_data_done & ~wr;
            e_dwen = req & ~m_data_done & wr;
            e_adv  = (~req | dh | m_data_done) & (ih | m_inst_done);
            e_dout = dh ? dl : (m_data_done ? m_dval : 32'h0);
        end
        check_eq("iREN", iREN, e_iren);
        check_eq("dREN", dREN, e_dren);
        check_eq("dWEN", dWEN, e_dwen);
        check_eq("advance", advance, e_adv);
        if (!rst) check_eq("dload_out", dload_out, e_dout);
        check_eq("halted", halted, m_halt);
        check_eq("err_timeout", err_timeout, m_err);
        check_eq("stall_cycles", stall_cycles, PERF ? m_stall : 32'h0);
        check_eq("dmem_ops", dmem_ops, PERF ? m_dops : 32'h0);

        if (rst) begin
            model_reset();
        end else begin
            if (!m_halt && !e_adv) m_stall++;
            if (dh) m_dops++;
            if (!m_halt && req && !dh && !m_data_done) begin
                if (m_pend == TO) m_err = 1;
                m_pend++;
            end else begin
                m_pend = 0;
            end
            if (e_adv) begin
                if (hlt) m_halt = 1;
                m_data_done = 0; m_inst_done = 0;
            end else begin
                if (ih) m_inst_done = 1;
                if (!m_halt && !m_data_done && req && dh) begin
                    m_data_done = 1; m_dval = dl;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_ins();  // one non-memory instruction with an instant fetch
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);
    endtask

    initial begin
        model_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 0, 1, 0, 32'h0);
        check_eq("rst_iren", s_iren, 1'b1);
        check_eq("rst_adv", s_adv, 1'b0);
        check_eq("rst_dren", s_dren, 1'b0);
        idle_ins();
        check_eq("post_rst_halted", s_halted, 1'b0);
        check_eq("post_rst_stall", s_stall, 32'h0);

        // Load, fetch ready, data hit three cycles after dREN.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 1, 0, 32'h0);
            check_eq("ld_wait_adv", s_adv, 1'b0);
            check_eq("ld_wait_dren", s_dren, 1'b1);
        end
        cycle(0, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF);
        check_eq("ld_hit_adv", s_adv, 1'b1);
        check_eq("ld_hit_data", s_dout, 32'hDEADBEEF);

        // Store: dhit at cycle 2, fetch only at cycle 5.
        for (int c = 0; c <= 5; c++) begin
            cycle(0, 0, 1, 0, 0, c == 5, c == 2, 32'h1234_5678);
            if (c <= 2) check_eq("st_dwen_early", s_dwen, 1'b1);
            else        check_eq("st_dwen_ddone", s_dwen, 1'b0);
            check_eq("st_adv", s_adv, c == 5);
        end

        // Squashed load: no dREN, advance tracks ihit.
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, 0, 1, 0, c == 2, 0, 32'h0);
            check_eq("sq_dren", s_dren, 1'b0);
            check_eq("sq_adv", s_adv, c == 2);
        end

        // Watchdog: dhit withheld through 8 DWAIT cycles.
        for (int c = 0; c <= 9; c++) begin
            cycle(0, 1, 0, 0, 0, 1, 0, 32'h0);
            check_eq("wd_err", s_err, c == 9);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 1, 1, 32'hCAFE0001);
        check_eq("wd_cleared", s_err, 1'b0);
        check_eq("wd_idle_adv", s_adv, 1'b1);

        // Halt: advances once, then frozen until reset.
        cycle(0, 0, 0, 0, 1, 1, 0, 32'h0);
        check_eq("halt_adv", s_adv, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, 0, 0, 0, 1, 1, 32'h0);
            check_eq("halt_halted", s_halted, 1'b1);
            check_eq("halt_iren", s_iren, 1'b0);
            check_eq("halt_adv_frozen", s_adv, 1'b0);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);

        // Ten instructions, two of them loads with two miss cycles each.
        for (int n = 0; n < 10; n++) begin
            if (n == 3 || n == 7) begin
                cycle(0, 1, 0, 0, 0, 1, 0, 32'h0);
                cycle(0, 1, 0, 0, 0, 1, 0, 32'h0);
                cycle(0, 1, 0, 0, 0, 1, 1, 32'h0000_0100 + n);
            end else begin
                idle_ins();
            end
        end
        idle_ins();
        check_eq("perf_dmem_ops", s_dops, PERF ? 32'd2 : 32'd0);
        check_eq("perf_stall", s_stall, PERF ? 32'd4 : 32'd0);

        // Randomized traffic; request lines held per instruction.
        begin
            bit rd = 0, wr = 0, sq = 0;
            for (int c = 0; c < 4000; c++) begin
                if (advance || $urandom_range(0, 7) == 0) begin
                    rd = ($urandom_range(0, 2) == 0);
                    wr = ($urandom_range(0, 3) == 0);
                    sq = ($urandom_range(0, 5) == 0);
                end
                if ($urandom_range(0, 15) == 0) sq = 1;
                cycle($urandom_range(0, 149) == 0, rd, wr, sq,
                      $urandom_range(0, 79) == 0,
                      $urandom_range(0, 2) != 0,
                      ($urandom_range(0, 9) < 3) || ($urandom_range(0, 40) == 0 && m_pend > 6),
                      $urandom);
                if (m_halt && $urandom_range(0, 5) == 0) cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
